// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake and operand/result bus for the shift-and-add multiplier.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    // Controlling FSM side: issues requests, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, product
    );

    // Multiplier side.
    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier: one partial-product row
// (multiplicand AND multiplier LSB) accumulated per cycle, WIDTH cycles per
// product, followed by a one-cycle done pulse.
module shift_add_multiplier #(
    parameter int WIDTH = 8,
    parameter int D     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product_r;

    logic [WIDTH-1:0]   pp;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] next_accmq;

    // D is a simulation-only delay hint with no functional meaning here.
    logic unused_d;
    assign unused_d = (D != 0);

    // Partial-product row, accumulate, and the shifted {acc,mq} pair; the
    // carry out of the add lands in the acc MSB after the right shift.
    always_comb begin
        pp         = mcand & {WIDTH{mq[0]}};
        sum        = {1'b0, acc} + {1'b0, pp};
        next_accmq = {sum, mq[WIDTH-1:1]};
    end

    // Control FSM and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            mq        <= '0;
            mcand     <= '0;
            count     <= '0;
            product_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.a;
                        mq    <= bus.b;
                        acc   <= '0;
                        count <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    {acc, mq} <= next_accmq;
                    count     <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        product_r <= next_accmq;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status is decoded straight from the state register.
    always_comb begin
        bus.busy    = (state == S_RUN);
        bus.done    = (state == S_DONE);
        bus.product = product_r;
    end
endmodule
